bf_host_port: RTL and testbench

BF_HOST_PORT -- requirements
Module: bf_host_port

---
 rtl/bf_pkg.sv | 21 ++
 rtl/bf_sync_fifo.sv | 50 +++++
 rtl/bf_host_port.sv | 144 ++++++++++++++
 tb/tb_bf_host_port.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared constants and FSM state types for the bf_machine host port.
package bf_pkg;

    localparam int WORD_SIZE = 8;

    localparam logic [WORD_SIZE-1:0] REQ_MARK = {WORD_SIZE{1'b1}};
    localparam logic [WORD_SIZE-1:0] OUT_MARK = {{(WORD_SIZE-1){1'b1}}, 1'b0};
    localparam logic [WORD_SIZE-1:0] ACK_VAL  = '0;

    typedef enum logic {
        OBS_IDLE,
        OBS_ARMED
    } obs_state_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_SYNC,
        I_DATA
    } in_state_t;

endpackage

// File: rtl/bf_sync_fifo.sv
// Single-clock FIFO with a registered write and a combinational head read.
// A pop frees the slot in the same cycle, so push+pop while full both succeed.
module bf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero when empty so the output is defined out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bf_host_port.sv
// Host-side port of a bf_machine: an observer that captures marked output words
// into a FIFO, and an input FSM that sends host words behind a held sync marker.
module bf_host_port #(
    parameter int WORD_SIZE   = bf_pkg::WORD_SIZE,
    parameter int HOLD_CYCLES = 16,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] machine_output,
    output logic [WORD_SIZE-1:0] machine_input,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 ovf_err,
    output logic                 rsv_err,
    output bf_pkg::obs_state_t   obs_state_dbg,
    output bf_pkg::in_state_t    in_state_dbg
);

    localparam logic [WORD_SIZE-1:0] REQ_W = {WORD_SIZE{1'b1}};
    localparam logic [WORD_SIZE-1:0] OUT_W = {{(WORD_SIZE-1){1'b1}}, 1'b0};
    localparam logic [WORD_SIZE-1:0] ACK_W = '0;
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    bf_pkg::obs_state_t   obs_state, obs_next;
    bf_pkg::in_state_t    in_state, in_next;
    logic [WORD_SIZE-1:0] obs_prev;
    logic [WORD_SIZE-1:0] word_q, word_next;
    logic [CW-1:0]        hold_cnt, hold_next;
    logic                 ovf_q, ovf_next;
    logic                 rsv_q, rsv_next;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                 transfer;

    // Both streams use valid/ready: a word moves on a cycle where valid && ready
    // are both high; the sender holds data stable while valid is high and ready low.
    assign in_ready = rst && (in_state == bf_pkg::I_IDLE) && (machine_output == REQ_W)
                      && (obs_state == bf_pkg::OBS_IDLE);
    assign transfer = in_valid && in_ready;

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    assign busy          = (in_state != bf_pkg::I_IDLE);
    assign ovf_err       = ovf_q;
    assign rsv_err       = rsv_q;
    assign obs_state_dbg = obs_state;
    assign in_state_dbg  = in_state;

    bf_sync_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (machine_output),
        .pop   (fifo_pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            obs_state <= bf_pkg::OBS_IDLE;
            in_state  <= bf_pkg::I_IDLE;
            obs_prev  <= REQ_W;
            word_q    <= '0;
            hold_cnt  <= '0;
            ovf_q     <= 1'b0;
            rsv_q     <= 1'b0;
        end else begin
            obs_state <= obs_next;
            in_state  <= in_next;
            obs_prev  <= machine_output;
            word_q    <= word_next;
            hold_cnt  <= hold_next;
            ovf_q     <= ovf_next;
            rsv_q     <= rsv_next;
        end
    end

    // Observer: arm on the leading edge of OUT_MARK, then the next change is data.
    always_comb begin
        obs_next  = obs_state;
        fifo_push = 1'b0;
        case (obs_state)
            bf_pkg::OBS_IDLE: begin
                if (machine_output == OUT_W && obs_prev != OUT_W) obs_next = bf_pkg::OBS_ARMED;
            end
            bf_pkg::OBS_ARMED: begin
                if (machine_output != obs_prev) begin
                    fifo_push = 1'b1;
                    obs_next  = bf_pkg::OBS_IDLE;
                end
            end
            default: obs_next = bf_pkg::OBS_IDLE;
        endcase
        ovf_next = ovf_q | (fifo_push && fifo_full && !fifo_pop);
    end

    always_comb begin
        in_next   = in_state;
        word_next = word_q;
        hold_next = hold_cnt;
        rsv_next  = rsv_q;
        case (in_state)
            bf_pkg::I_IDLE: begin
                if (transfer) begin
                    if (in_data == REQ_W) begin
                        rsv_next = 1'b1;
                    end else begin
                        word_next = in_data;
                        hold_next = CW'(HOLD_CYCLES - 1);
                        in_next   = bf_pkg::I_SYNC;
                    end
                end
            end
            bf_pkg::I_SYNC: begin
                if (hold_cnt == '0) in_next = bf_pkg::I_DATA;
                else                hold_next = hold_cnt - CW'(1);
            end
            bf_pkg::I_DATA: begin
                if (machine_output == ACK_W) in_next = bf_pkg::I_IDLE;
            end
            default: in_next = bf_pkg::I_IDLE;
        endcase
    end

    always_comb begin
        case (in_state)
            bf_pkg::I_SYNC: machine_input = REQ_W;
            bf_pkg::I_DATA: machine_input = word_q;
            default:        machine_input = ACK_W;
        endcase
    end

endmodule

// File: tb/tb_bf_host_port.sv
// Bench for bf_host_port: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model of the port.
module tb_bf_host_port;
    import bf_pkg::*;

    localparam int W     = 8;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] mo = '0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] machine_input;
    logic [W-1:0] out_data;
    logic         in_ready, out_valid, busy, ovf_err, rsv_err;
    obs_state_t   obs_dbg;
    in_state_t    in_dbg;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit cap_en = 1'b0;
    logic [W-1:0] cap_q[$];

    bf_host_port #(
        .WORD_SIZE   (W),
        .HOLD_CYCLES (HOLD),
        .OUT_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .machine_output (mo),
        .machine_input  (machine_input),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .ovf_err        (ovf_err),
        .rsv_err        (rsv_err),
        .obs_state_dbg  (obs_dbg),
        .in_state_dbg   (in_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: mode 0 idle, 1 sending sync, 2 presenting the word.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_prev = 8'hFF;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_pw;
    bit m_armed = 0, m_ovf = 0, m_rsv = 0, m_pop, m_push, m_rdy;
    int m_mode = 0, m_left = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prev = 8'hFF; m_armed = 0; exp_q.delete();
            m_mode = 0; m_left = 0; m_word = '0; m_ovf = 0; m_rsv = 0;
        end else begin
            m_rdy  = (m_mode == 0) && (mo == 8'hFF) && !m_armed;
            m_pop  = (exp_q.size() > 0) && out_ready;
            m_push = 0;
            if (m_armed) begin
                if (mo != m_prev) begin m_push = 1; m_pw = mo; m_armed = 0; end
            end else if (mo == 8'hFE && m_prev != 8'hFE) begin
                m_armed = 1;
            end
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_pw);
                else m_ovf = 1;
            end
            case (m_mode)
                0: if (in_valid && m_rdy) begin
                       if (in_data == 8'hFF) m_rsv = 1;
                       else begin m_word = in_data; m_mode = 1; m_left = HOLD; end
                   end
                1: begin m_left--; if (m_left == 0) m_mode = 2; end
                default: if (mo == 8'h00) m_mode = 0;
            endcase
            m_prev = mo;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("machine_input", machine_input, (m_mode == 1) ? 8'hFF : (m_mode == 2) ? m_word : 8'h00);
            check("busy", busy, m_mode != 0);
            check("in_ready", in_ready, rst && (m_mode == 0) && (mo == 8'hFF) && !m_armed);
            check("out_valid", out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
            check("ovf_err", ovf_err, m_ovf);
            check("rsv_err", rsv_err, m_rsv);
        end
        if (cap_en && out_valid && out_ready) cap_q.push_back(out_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] in_words[6] = '{8'd1, 8'd5, 8'd10, 8'hFC, 8'hF8, 8'd0};
    int           exp_sums[5] = '{1, 6, 16, 12, 4};

    initial begin
        int n;
        int sum;
        logic [W-1:0] word;

        // Reset values, with REQ_MARK on the bus to show in_ready stays low.
        mo = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_machine_input", machine_input, 8'h00);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {ovf_err, rsv_err}, 2'b00);
        mo = 8'h00;
        rst = 1'b1;
        chk_en = 1'b1;
        step();

        // Output path: 00, FE, 2A.
        mo = 8'h00; step();
        mo = 8'hFE; step();
        mo = 8'h2A; step();
        check("out_path_valid", out_valid, 1'b1);
        check("out_path_data", out_data, 8'h2A);
        step();
        check("out_path_hold", out_data, 8'h2A);
        out_ready = 1'b1; step();
        check("out_path_popped", out_valid, 1'b0);

        // Input path with a 4-cycle sync hold.
        mo = 8'hFF; in_data = 8'h05; in_valid = 1'b1;
        #1;
        check("in_path_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            check("in_path_sync", machine_input, 8'hFF);
            step();
        end
        check("in_path_data", machine_input, 8'h05);
        step();
        check("in_path_data_held", machine_input, 8'h05);
        mo = 8'h00; step();
        check("in_path_busy_done", busy, 1'b0);
        check("in_path_ack", machine_input, 8'h00);

        // Reserved host word is swallowed.
        mo = 8'hFF; in_data = 8'hFF; in_valid = 1'b1; step();
        in_valid = 1'b0;
        check("rsv_flag", rsv_err, 1'b1);
        check("rsv_no_sync", machine_input, 8'h00);
        mo = 8'h00; step();

        // FE then FF: FF is output data, not an input request.
        mo = 8'hFE; in_data = 8'h33; in_valid = 1'b1; step();
        mo = 8'hFF;
        #1;
        check("prio_in_ready", in_ready, 1'b0);
        step();
        in_valid = 1'b0;
        check("prio_capture_valid", out_valid, 1'b1);
        check("prio_capture_data", out_data, 8'hFF);
        check("prio_no_busy", busy, 1'b0);
        mo = 8'h00; step();

        // Overflow: five marked words into a depth-4 FIFO.
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            mo = 8'hFE; step();
            mo = W'(v); step();
            if (v == 4) check("ovf_not_yet", ovf_err, 1'b0);
        end
        mo = 8'h00; step();
        check("ovf_flag", ovf_err, 1'b1);
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            check("ovf_contents", out_data, W'(v));
            step();
        end
        check("ovf_drained", out_valid, 1'b0);

        // Reset in the middle of a sync hold.
        mo = 8'hFF; in_data = 8'h11; in_valid = 1'b1; step();
        in_valid = 1'b0;
        step(); step();
        check("mid_sync_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_mi", machine_input, 8'h00);
        check("async_rst_busy", busy, 1'b0);
        step(); step();
        rst = 1'b1;
        repeat (3) step();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_errs", {ovf_err, rsv_err}, 2'b00);

        // Summing bf_machine emulation: read until 0, output running sums.
        mo = 8'h00; out_ready = 1'b1; step();
        cap_q.delete();
        cap_en = 1'b1;
        sum = 0;
        for (int k = 0; k < 6; k++) begin
            in_data = in_words[k]; in_valid = 1'b1; mo = 8'hFF;
            #1;
            n = 0;
            while (!in_ready && n < 50) begin step(); n++; end
            check("sum_ready_wait", n < 50, 1'b1);
            step();
            in_valid = 1'b0;
            n = 0;
            while ((machine_input == 8'hFF || !busy) && n < 50) begin step(); n++; end
            check("sum_data_wait", n < 50, 1'b1);
            word = machine_input;
            check("sum_word", word, in_words[k]);
            mo = 8'h00; step();
            if (word != 8'h00) begin
                sum += int'($signed(word));
                mo = 8'hFE; step();
                mo = W'(sum); step();
            end
        end
        mo = 8'h00;
        repeat (4) step();
        cap_en = 1'b0;
        check("sum_count", cap_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < cap_q.size()) check("sum_value", cap_q[i], W'(exp_sums[i]));
        end

        // Random traffic against the model, with occasional reset pulses.
        for (int c = 0; c < 2500; c++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 2)      mo = 8'h00;
            else if (r <= 4) mo = 8'hFE;
            else if (r <= 6) mo = 8'hFF;
            else             mo = W'($urandom_range(0, 255));
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0; step(); rst = 1'b1;
            end
            step();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
